// File: rtl/sumador_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package sumador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit-counter width for a given operand width, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sumador_completo.sv
// Combinational 1-bit full adder cell used by the serial datapath.
module sumador_completo (
  input  logic A,
  input  logic B,
  input  logic CIn,
  output logic Sum,
  output logic COut
);

  assign Sum  = A ^ B ^ CIn;
  assign COut = (A & B) | (CIn & (A ^ B));

endmodule

// File: rtl/sumador_serie.sv
// Bit-serial adder/subtractor, LSB first, one full-adder cell, done pulse on completion.
// Define SUMADOR_SERIE_OVF_EN to add the registered signed-overflow output ovf.
module sumador_serie
  import sumador_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SUMADOR_SERIE_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;

  logic             s_bit;
  logic             c_bit;
  logic             last;
  logic [WIDTH:0]   res_cat;
  logic [WIDTH-1:0] res_nxt;
  logic             unused_res_lsb;

  sumador_completo u_fa (
    .A   (a_q[0]),
    .B   (b_q[0]),
    .CIn (carry_q),
    .Sum (s_bit),
    .COut(c_bit)
  );

  // New bit enters at the MSB; after WIDTH shifts the first bit sits at the LSB.
  assign res_cat        = {s_bit, res_q};
  assign res_nxt        = res_cat[WIDTH:1];
  assign unused_res_lsb = res_cat[0];
  assign last           = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SUMADOR_SERIE_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;  // +1 of the two's complement negation
            cnt_q   <= '0;
            res_q   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= c_bit;
          res_q   <= res_nxt;
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= res_nxt;
            cout  <= c_bit;
`ifdef SUMADOR_SERIE_OVF_EN
            ovf   <= carry_q ^ c_bit;  // carry into MSB vs carry out of MSB
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sumador_serie.sv
// Self-checking bench for sumador_serie (WIDTH=8): directed table, corner sequences, random vs model.
module tb_sumador_serie;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_chk;
  int n_fail;

  sumador_serie #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
`ifdef SUMADOR_SERIE_OVF_EN
    .ovf  (ovf),
`endif
    .cout (cout)
  );

`ifndef SUMADOR_SERIE_OVF_EN
  assign ovf = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vsub;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                output logic [W-1:0] r, output logic c, output logic v);
    int ux;
    int uy;
    int sx;
    int sy;
    int ures;
    int sres;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    if (!s) begin
      ures = ux + uy;
      sres = sx + sy;
      c    = (ures >= 256);
    end else begin
      ures = ux - uy + 256;
      sres = sx - sy;
      c    = (ux >= uy);
    end
    r = W'(ures % 256);
    v = (sres > 127) || (sres < -128);
  endfunction

  // Runs one operation and checks latency, busy length, done width and result.
  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic s, input logic [W-1:0] esum, input logic ecout,
                       input logic eovf);
    int cyc;
    int bcnt;
    int both;
    @(negedge clk);
    a = x;
    b = y;
    sub = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    sub = $urandom;
    cyc = 0;
    bcnt = 0;
    both = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (busy && done) both++;
    chk({tag, " latency"}, cyc, W);
    chk({tag, " busy_cycles"}, bcnt, W);
    chk({tag, " busy_with_done"}, both, 0);
    chk({tag, " sum"}, sum, esum);
    chk({tag, " cout"}, cout, ecout);
`ifdef SUMADOR_SERIE_OVF_EN
    chk({tag, " ovf"}, ovf, eovf);
`else
    if (eovf === 1'bx) chk({tag, " ovf_x"}, ovf, 0);
`endif
    @(posedge clk);
    #1;
    chk({tag, " done_pulse_width"}, done, 0);
  endtask

  vec_t vecs[5];

  initial begin
    logic [W-1:0] rs;
    logic         rc;
    logic         rv;
    logic [W-1:0] held;
    int           ndone;

    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    start = 1'b0;
    sub = 1'b0;
    a = '0;
    b = '0;

    vecs[0] = '{va: 8'd100, vb: 8'd55,  vsub: 1'b0, esum: 8'h9B, ecout: 1'b0, eovf: 1'b1};
    vecs[1] = '{va: 8'hFF,  vb: 8'h01,  vsub: 1'b0, esum: 8'h00, ecout: 1'b1, eovf: 1'b0};
    vecs[2] = '{va: 8'h80,  vb: 8'h80,  vsub: 1'b0, esum: 8'h00, ecout: 1'b1, eovf: 1'b1};
    vecs[3] = '{va: 8'd5,   vb: 8'd7,   vsub: 1'b1, esum: 8'hFE, ecout: 1'b0, eovf: 1'b0};
    vecs[4] = '{va: 8'd7,   vb: 8'd5,   vsub: 1'b1, esum: 8'h02, ecout: 1'b1, eovf: 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst sum", sum, 0);
    chk("rst cout", cout, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (busy || done) ndone++;
    end
    chk("idle_no_activity", ndone, 0);

    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vsub,
            vecs[i].esum, vecs[i].ecout, vecs[i].eovf);
    end

    // Result holds through IDLE
    repeat (4) @(posedge clk);
    #1;
    chk("hold_in_idle", sum, 8'h02);

    // Start pulsed during RUN must be ignored; sum not cleared by start
    @(negedge clk);
    a = 8'd3;
    b = 8'd4;
    sub = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("sum_not_cleared_on_start", sum, 8'h02);
    repeat (2) @(posedge clk);
    #1;
    a = 8'd1;
    b = 8'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    repeat (16) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("ignored_start done_count", ndone, 1);
    chk("ignored_start sum", sum, 8'd7);
    chk("ignored_start idle", busy, 0);

    // Reset in the 4th RUN cycle aborts with no done
    @(negedge clk);
    a = 8'd50;
    b = 8'd60;
    sub = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst sum", sum, 0);
    chk("midrst cout", cout, 0);
    chk("midrst ovf", ovf, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    chk("midrst no_done", ndone, 0);
    do_op("after_rst", 8'd10, 8'd20, 1'b0, 8'd30, 1'b0, 1'b0);

    // Randomised operations against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         s;
      x = W'($urandom);
      y = W'($urandom);
      s = 1'($urandom_range(0, 1));
      if (i == 0) begin
        x = 8'h7F;
        y = 8'h01;
        s = 1'b0;
      end
      if (i == 1) begin
        x = 8'h80;
        y = 8'h01;
        s = 1'b1;
      end
      model(x, y, s, rs, rc, rv);
      do_op($sformatf("rnd%0d", i), x, y, s, rs, rc, rv);
    end

    held = sum;
    repeat (3) @(posedge clk);
    #1;
    chk("final_hold", sum, held);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
